// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port between pipeline writeback and a queued multi-cycle unit
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mc_valid,
  input  logic [4:0]  mc_waddr,
  input  logic [31:0] mc_wdata,
  output logic        mc_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        stall_req
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_d;
  logic          pipe_grant, nonempty, pop, push, head_we;
  // Port arbitration: pipeline first, then FIFO head; a full FIFO still accepts when its head leaves
  always_comb begin
    pipe_grant = !rst && pipe_we && |pipe_waddr;
    nonempty   = count_q != '0;
    pop        = !rst && !pipe_grant && nonempty;
    mc_ready   = !rst && (count_q < CW'(DEPTH) || pop);
    push       = mc_valid && mc_ready && |mc_waddr;
    head_we    = pop && vld_q[rptr_q];
    rf_we      = pipe_grant || head_we;
    rf_waddr   = pipe_grant ? pipe_waddr : head_we ? addr_q[rptr_q] : '0;
    rf_wdata   = pipe_grant ? pipe_wdata : head_we ? data_q[rptr_q] : '0;
  end
  // Pending-write lookup for decode, against entries held before this cycle's pop/push
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_hit1 = pend_hit1 | (vld_q[i] && addr_q[i] == raddr1);
      pend_hit2 = pend_hit2 | (vld_q[i] && addr_q[i] == raddr2);
    end
    pend_hit1 = pend_hit1 && !rst && |raddr1;
    pend_hit2 = pend_hit2 && !rst && |raddr2;
  end
  // FIFO and starvation next state; a pipeline write kills older queued writes to the same register
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    vld_d  = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (pipe_grant && addr_q[i] == pipe_waddr) vld_d[i] = 1'b0;
    if (pop) vld_d[rptr_q] = 1'b0;
    if (push) begin
      addr_d[wptr_q] = mc_waddr;
      data_d[wptr_q] = mc_wdata;
      vld_d[wptr_q]  = 1'b1;
    end
    rptr_d   = rptr_q + AW'(pop);
    wptr_d   = wptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    stall_d  = starve_q == SW'(STARVE_LIMIT);
    starve_d = (stall_d || pop) ? '0 : (nonempty && pipe_we) ? starve_q + 1'b1 : starve_q;
  end
  // State registers; queued payloads need no reset since their valid bits are cleared
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    if (rst) begin
      vld_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_req <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_req <= stall_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed-vector bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 0, rst = 1;
  logic        pipe_we = 0, mc_valid = 0;
  logic [4:0]  pipe_waddr = 0, mc_waddr = 0, raddr1 = 0, raddr2 = 0;
  logic [31:0] pipe_wdata = 0, mc_wdata = 0;
  logic        mc_ready, rf_we, pend_hit1, pend_hit2, stall_req;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] reg7 = 0;
  int vec = 0, err = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we && rf_waddr == 5'd7) reg7 <= rf_wdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h33; mc_valid = 1; mc_waddr = 4;
    tick; tick;
    #1;
    vec++; if (rf_we !== 1'b0) begin err++; $display("FAIL reset_rf_we got %0h exp 0", rf_we); end
    vec++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin err++; $display("FAIL reset_rf_addr_data got %0h/%0h exp 0/0", rf_waddr, rf_wdata); end
    vec++; if (mc_ready !== 1'b0) begin err++; $display("FAIL reset_mc_ready got %0h exp 0", mc_ready); end
    vec++; if (stall_req !== 1'b0) begin err++; $display("FAIL reset_stall got %0h exp 0", stall_req); end
    rst = 0; pipe_we = 0; mc_valid = 0;
    #1;
    vec++; if (mc_ready !== 1'b1 || rf_we !== 1'b0) begin err++; $display("FAIL idle_after_reset got ready=%0h we=%0h exp 1/0", mc_ready, rf_we); end
  endtask

  task automatic test_single;
    tick;
    pipe_we = 0; mc_valid = 1; mc_waddr = 5; mc_wdata = 32'hA5A5A5A5; raddr1 = 5;
    #1;
    vec++; if (mc_ready !== 1'b1 || rf_we !== 1'b0) begin err++; $display("FAIL single_accept got ready=%0h we=%0h exp 1/0", mc_ready, rf_we); end
    tick;
    mc_valid = 0;
    #1;
    vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hA5A5A5A5) begin err++; $display("FAIL single_write got %0h/%0h/%h exp 1/5/a5a5a5a5", rf_we, rf_waddr, rf_wdata); end
    vec++; if (pend_hit1 !== 1'b1) begin err++; $display("FAIL single_pend got %0h exp 1", pend_hit1); end
    tick;
    vec++; if (rf_we !== 1'b0 || pend_hit1 !== 1'b0) begin err++; $display("FAIL single_empty got we=%0h hit=%0h exp 0/0", rf_we, pend_hit1); end
  endtask

  task automatic test_starve;
    pipe_we = 1; pipe_waddr = 1; pipe_wdata = 32'h100; raddr2 = 12;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1; mc_waddr = 5'(10 + i); mc_wdata = 32'hB0 + i;
      #1;
      vec++; if (mc_ready !== 1'b1) begin err++; $display("FAIL starve_ready%0d got %0h exp 1", i, mc_ready); end
      tick;
    end
    mc_waddr = 20;
    #1;
    vec++; if (mc_ready !== 1'b0) begin err++; $display("FAIL starve_full got %0h exp 0", mc_ready); end
    vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h100) begin err++; $display("FAIL starve_pipe_prio got %0h/%0h/%h exp 1/1/100", rf_we, rf_waddr, rf_wdata); end
    vec++; if (pend_hit2 !== 1'b1) begin err++; $display("FAIL starve_pend2 got %0h exp 1", pend_hit2); end
    mc_valid = 0;
    for (int k = 0; k < 6; k++) begin
      vec++; if (stall_req !== 1'b0) begin err++; $display("FAIL starve_early%0d got %0h exp 0", k, stall_req); end
      tick;
    end
    vec++; if (stall_req !== 1'b1) begin err++; $display("FAIL starve_stall got %0h exp 1", stall_req); end
    pipe_we = 0;
    #1;
    vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hB0) begin err++; $display("FAIL starve_head got %0h/%0h/%h exp 1/a/b0", rf_we, rf_waddr, rf_wdata); end
    tick;
    vec++; if (stall_req !== 1'b0) begin err++; $display("FAIL starve_one_cycle got %0h exp 0", stall_req); end
    for (int i = 1; i < 4; i++) begin
      vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== 32'hB0 + i) begin err++; $display("FAIL starve_drain%0d got %0h/%0h/%h", i, rf_we, rf_waddr, rf_wdata); end
      tick;
    end
    vec++; if (rf_we !== 1'b0) begin err++; $display("FAIL starve_drained got %0h exp 0", rf_we); end
  endtask

  task automatic test_invalidate;
    pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h33; mc_valid = 1; mc_waddr = 7; mc_wdata = 32'h77; raddr1 = 7;
    tick;
    mc_valid = 0; pipe_waddr = 7; pipe_wdata = 32'h11;
    #1;
    vec++; if (pend_hit1 !== 1'b1) begin err++; $display("FAIL inval_pend_before got %0h exp 1", pend_hit1); end
    vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11) begin err++; $display("FAIL inval_pipe_write got %0h/%0h/%h exp 1/7/11", rf_we, rf_waddr, rf_wdata); end
    tick;
    pipe_we = 0;
    #1;
    vec++; if (pend_hit1 !== 1'b0) begin err++; $display("FAIL inval_pend_after got %0h exp 0", pend_hit1); end
    vec++; if (rf_we !== 1'b0) begin err++; $display("FAIL inval_pop_we got %0h exp 0", rf_we); end
    tick; tick;
    vec++; if (reg7 !== 32'h11) begin err++; $display("FAIL inval_reg7 got %h exp 11", reg7); end
  endtask

  task automatic test_full_swap;
    pipe_we = 1; pipe_waddr = 2; pipe_wdata = 32'h22; raddr1 = 0;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1; mc_waddr = 5'(20 + i); mc_wdata = 32'hC0 + i;
      tick;
    end
    pipe_we = 0; mc_waddr = 24; mc_wdata = 32'hC4;
    #1;
    vec++; if (mc_ready !== 1'b1) begin err++; $display("FAIL swap_ready got %0h exp 1", mc_ready); end
    vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20) begin err++; $display("FAIL swap_pop got %0h/%0h exp 1/14", rf_we, rf_waddr); end
    tick;
    mc_valid = 0; pipe_we = 1;
    #1;
    vec++; if (mc_ready !== 1'b0) begin err++; $display("FAIL swap_still_full got %0h exp 0", mc_ready); end
    pipe_we = 0;
    for (int i = 1; i < 5; i++) begin
      #1;
      vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'(20 + i) || rf_wdata !== 32'hC0 + i) begin err++; $display("FAIL swap_drain%0d got %0h/%0h/%h", i, rf_we, rf_waddr, rf_wdata); end
      tick;
    end
    vec++; if (rf_we !== 1'b0) begin err++; $display("FAIL swap_drained got %0h exp 0", rf_we); end
  endtask

  task automatic test_zero_addr;
    pipe_we = 0; mc_valid = 1; mc_waddr = 0; mc_wdata = 32'hDEAD; raddr1 = 0;
    #1;
    vec++; if (mc_ready !== 1'b1 || pend_hit1 !== 1'b0) begin err++; $display("FAIL zero_accept got ready=%0h hit=%0h exp 1/0", mc_ready, pend_hit1); end
    tick;
    mc_valid = 0; pipe_we = 1; pipe_waddr = 0; pipe_wdata = 32'h5;
    #1;
    vec++; if (rf_we !== 1'b0) begin err++; $display("FAIL zero_no_write got %0h exp 0", rf_we); end
    tick;
    pipe_we = 0;
  endtask

  task automatic test_mid_reset;
    pipe_we = 1; pipe_waddr = 4; pipe_wdata = 32'h44; raddr1 = 25;
    for (int i = 0; i < 3; i++) begin
      mc_valid = 1; mc_waddr = 5'(25 + i); mc_wdata = 32'hE0 + i;
      tick;
    end
    rst = 1;
    #1;
    vec++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin err++; $display("FAIL mrst_rf got %0h/%0h/%h exp 0", rf_we, rf_waddr, rf_wdata); end
    vec++; if (mc_ready !== 1'b0 || pend_hit1 !== 1'b0) begin err++; $display("FAIL mrst_ready_hit got %0h/%0h exp 0/0", mc_ready, pend_hit1); end
    tick;
    rst = 0; pipe_we = 0; mc_valid = 0;
    #1;
    vec++; if (mc_ready !== 1'b1) begin err++; $display("FAIL mrst_ready_after got %0h exp 1", mc_ready); end
    for (int k = 0; k < 4; k++) begin
      #1;
      vec++; if (rf_we !== 1'b0 || pend_hit1 !== 1'b0) begin err++; $display("FAIL mrst_stale%0d got we=%0h hit=%0h exp 0/0", k, rf_we, pend_hit1); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_starve;
    test_invalidate;
    test_full_swap;
    test_zero_addr;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
